// File: rtl/dcache_l2_wbuf.sv
// Posted write buffer between the L2 data cache memory port and main memory.
// Write-backs are acknowledged on enqueue and drained in FIFO order; reads forward from the buffer.
module dcache_l2_wbuf #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic         clk,
    input  logic         proc_reset_n,
    input  logic         l2_read,
    input  logic         l2_write,
    input  logic [27:0]  l2_addr,
    input  logic [127:0] l2_wdata,
    output logic [127:0] l2_rdata,
    output logic         l2_ready,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready,
    output logic         wbuf_empty
);

    localparam logic [1:0] U_IDLE   = 2'd0;
    localparam logic [1:0] U_ACK    = 2'd1;
    localparam logic [1:0] U_RDMISS = 2'd2;

    localparam logic [1:0] M_IDLE  = 2'd0;
    localparam logic [1:0] M_READ  = 2'd1;
    localparam logic [1:0] M_WRITE = 2'd2;

    logic [1:0]       r_ustate;
    logic [1:0]       r_mstate;
    logic [27:0]      r_ent_addr [DEPTH];
    logic [127:0]     r_ent_data [DEPTH];
    logic [DEPTH-1:0] r_ent_valid;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic [127:0]     r_l2_rdata;
    logic [27:0]      r_mem_addr;
    logic [127:0]     r_mem_wdata;

    logic             w_read;
    logic             w_write;
    logic             w_full;
    logic             w_enq;
    logic             w_deq;
    logic             w_hit;
    logic             w_rd_miss;
    logic [PTR_W-1:0] w_hit_idx;
    logic [PTR_W-1:0] w_scan_idx;

    assign w_read    = l2_read & ~l2_write;
    assign w_write   = l2_write & ~l2_read;
    assign w_full    = (r_count == (PTR_W+1)'(DEPTH));
    assign w_enq     = (r_ustate == U_IDLE) && w_write && !w_full;
    assign w_deq     = (r_mstate == M_WRITE) && mem_ready;
    assign w_rd_miss = (r_ustate == U_IDLE) && w_read && !w_hit;

    // Scan oldest to youngest so the last match found is the youngest copy.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_scan_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_scan_idx = r_rd_ptr + PTR_W'(i);
            if (r_ent_valid[w_scan_idx] && (r_ent_addr[w_scan_idx] == l2_addr)) begin
                w_hit     = 1'b1;
                w_hit_idx = w_scan_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_ent_addr[r_wr_ptr] <= l2_addr;
            r_ent_data[r_wr_ptr] <= l2_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!proc_reset_n) begin
            r_ent_valid <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
        end else begin
            if (w_deq) begin
                r_ent_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr              <= r_rd_ptr + PTR_W'(1);
            end
            if (w_enq) begin
                r_ent_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr              <= r_wr_ptr + PTR_W'(1);
            end
            if (w_enq && !w_deq) begin
                r_count <= r_count + (PTR_W+1)'(1);
            end else if (!w_enq && w_deq) begin
                r_count <= r_count - (PTR_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!proc_reset_n) begin
            r_ustate   <= U_IDLE;
            r_l2_rdata <= '0;
        end else begin
            case (r_ustate)
                U_IDLE: begin
                    if (w_enq) begin
                        r_ustate <= U_ACK;
                    end else if (w_read && w_hit) begin
                        r_l2_rdata <= r_ent_data[w_hit_idx];
                        r_ustate   <= U_ACK;
                    end else if (w_read) begin
                        r_ustate <= U_RDMISS;
                    end
                end
                U_ACK: r_ustate <= U_IDLE;
                U_RDMISS: begin
                    if ((r_mstate == M_READ) && mem_ready) begin
                        r_l2_rdata <= mem_rdata;
                        r_ustate   <= U_ACK;
                    end
                end
                default: r_ustate <= U_IDLE;
            endcase
        end
    end

    // Drains are held off while a refill read may be arriving, so it reaches memory first.
    always_ff @(posedge clk) begin
        if (!proc_reset_n) begin
            r_mstate    <= M_IDLE;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_mstate)
                M_IDLE: begin
                    if (r_ustate == U_RDMISS) begin
                        r_mstate   <= M_READ;
                        r_mem_addr <= l2_addr;
                    end else if ((r_count != '0) && (r_ustate != U_ACK) && !w_rd_miss) begin
                        r_mstate    <= M_WRITE;
                        r_mem_addr  <= r_ent_addr[r_rd_ptr];
                        r_mem_wdata <= r_ent_data[r_rd_ptr];
                    end
                end
                M_READ, M_WRITE: begin
                    if (mem_ready) begin
                        r_mstate <= M_IDLE;
                    end
                end
                default: r_mstate <= M_IDLE;
            endcase
        end
    end

    assign l2_rdata   = r_l2_rdata;
    assign l2_ready   = (r_ustate == U_ACK);
    assign mem_read   = (r_mstate == M_READ);
    assign mem_write  = (r_mstate == M_WRITE);
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign wbuf_empty = (r_count == '0) && (r_mstate == M_IDLE);

endmodule

// File: tb/tb_dcache_l2_wbuf.sv
// Bench for dcache_l2_wbuf: per-cycle vector table, then hand sequences for
// full-buffer stall, dirty-eviction ordering and mid-drain reset.
module tb_dcache_l2_wbuf;

    logic         clk = 1'b0;
    logic         proc_reset_n;
    logic         l2_read, l2_write;
    logic [27:0]  l2_addr;
    logic [127:0] l2_wdata, l2_rdata;
    logic         l2_ready, mem_read, mem_write, mem_ready, wbuf_empty;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    dcache_l2_wbuf #(.DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .proc_reset_n(proc_reset_n),
        .l2_read(l2_read), .l2_write(l2_write), .l2_addr(l2_addr), .l2_wdata(l2_wdata),
        .l2_rdata(l2_rdata), .l2_ready(l2_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .wbuf_empty(wbuf_empty)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic rd; logic wr; logic [27:0] addr; logic [127:0] wdata; logic mr;
        logic e_rdy; logic e_mrd; logic e_mwr; logic [27:0] e_maddr; logic [127:0] e_mwdata;
        logic c_rdata; logic [127:0] e_rdata; logic e_emp;
    } vec_t;

    function automatic vec_t mk(logic rd, logic wr, logic [27:0] addr, logic [127:0] wdata,
                                logic mr, logic e_rdy, logic e_mrd, logic e_mwr,
                                logic [27:0] e_maddr, logic [127:0] e_mwdata, logic c_rdata,
                                logic [127:0] e_rdata, logic e_emp);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.mr = mr;
        v.e_rdy = e_rdy; v.e_mrd = e_mrd; v.e_mwr = e_mwr; v.e_maddr = e_maddr;
        v.e_mwdata = e_mwdata; v.c_rdata = c_rdata; v.e_rdata = e_rdata; v.e_emp = e_emp;
        return v;
    endfunction

    // Scoreboard of expected memory writes, checked whenever a write is acknowledged.
    logic         sb_on = 1'b0;
    logic [27:0]  sb_addr [$];
    logic [127:0] sb_data [$];

    always @(negedge clk) begin
        if (sb_on && mem_write && mem_ready) begin
            if (sb_addr.size() == 0) begin
                chk("sb_unexpected_write", {100'd0, mem_addr}, 128'hDEAD);
            end else begin
                chk("sb_write_addr", {100'd0, mem_addr}, {100'd0, sb_addr.pop_front()});
                chk("sb_write_data", mem_wdata, sb_data.pop_front());
            end
        end
    end

    task automatic do_write(input logic [27:0] a, input logic [127:0] d);
        logic got;
        got      = 1'b0;
        l2_write = 1'b1;
        l2_read  = 1'b0;
        l2_addr  = a;
        l2_wdata = d;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (l2_ready) begin
                got = 1'b1;
                break;
            end
        end
        chk("write_ack_seen", {127'd0, got}, 128'd1);
        l2_write = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        logic got;
        got = 1'b0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (wbuf_empty) begin
                got = 1'b1;
                break;
            end
        end
        chk(name, {127'd0, got}, 128'd1);
    endtask

    localparam logic [27:0]  A  = 28'h0000010;
    localparam logic [127:0] D1 = {4{32'h1111_1111}};
    localparam logic [127:0] D2 = {4{32'h2222_2222}};

    vec_t vecs [18];

    initial begin
        vecs[0]  = mk(0, 1, A, D1, 0, 1, 0, 0, 0, 0,  0, 0,  0);
        vecs[1]  = mk(0, 1, A, D1, 0, 0, 0, 0, 0, 0,  0, 0,  0);
        vecs[2]  = mk(0, 0, A, 0,  0, 0, 0, 1, A, D1, 0, 0,  0);
        vecs[3]  = mk(0, 0, A, 0,  0, 0, 0, 1, A, D1, 0, 0,  0);
        vecs[4]  = mk(0, 0, A, 0,  1, 0, 0, 0, 0, 0,  0, 0,  1);
        vecs[5]  = mk(0, 1, A, D1, 0, 1, 0, 0, 0, 0,  0, 0,  0);
        vecs[6]  = mk(0, 1, A, D1, 0, 0, 0, 0, 0, 0,  0, 0,  0);
        vecs[7]  = mk(1, 0, A, 0,  0, 1, 0, 1, A, D1, 1, D1, 0);
        vecs[8]  = mk(1, 0, A, 0,  0, 0, 0, 1, A, D1, 1, D1, 0);
        vecs[9]  = mk(0, 0, A, 0,  1, 0, 0, 0, 0, 0,  1, D1, 1);
        vecs[10] = mk(0, 1, A, D1, 0, 1, 0, 0, 0, 0,  0, 0,  0);
        vecs[11] = mk(0, 1, A, D1, 0, 0, 0, 0, 0, 0,  0, 0,  0);
        vecs[12] = mk(0, 1, A, D2, 0, 1, 0, 1, A, D1, 0, 0,  0);
        vecs[13] = mk(0, 1, A, D2, 0, 0, 0, 1, A, D1, 0, 0,  0);
        vecs[14] = mk(1, 0, A, 0,  0, 1, 0, 1, A, D1, 1, D2, 0);
        vecs[15] = mk(1, 0, A, 0,  1, 0, 0, 0, 0, 0,  1, D2, 0);
        vecs[16] = mk(0, 0, A, 0,  0, 0, 0, 1, A, D2, 0, 0,  0);
        vecs[17] = mk(0, 0, A, 0,  1, 0, 0, 0, 0, 0,  0, 0,  1);

        proc_reset_n = 1'b0;
        l2_read = 1'b0; l2_write = 1'b0; l2_addr = '0; l2_wdata = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        tick();
        tick();
        chk("rst_ready", {127'd0, l2_ready}, 128'd0);
        chk("rst_rdata", l2_rdata, 128'd0);
        chk("rst_mem_read", {127'd0, mem_read}, 128'd0);
        chk("rst_mem_write", {127'd0, mem_write}, 128'd0);
        chk("rst_mem_addr", {100'd0, mem_addr}, 128'd0);
        chk("rst_mem_wdata", mem_wdata, 128'd0);
        chk("rst_empty", {127'd0, wbuf_empty}, 128'd1);
        proc_reset_n = 1'b1;
        tick();

        // Single write drain, forwarded read, youngest-match forwarding with FIFO drain.
        for (int i = 0; i < 18; i++) begin
            l2_read   = vecs[i].rd;
            l2_write  = vecs[i].wr;
            l2_addr   = vecs[i].addr;
            l2_wdata  = vecs[i].wdata;
            mem_ready = vecs[i].mr;
            tick();
            chk($sformatf("v%0d_ready", i), {127'd0, l2_ready}, {127'd0, vecs[i].e_rdy});
            chk($sformatf("v%0d_mem_read", i), {127'd0, mem_read}, {127'd0, vecs[i].e_mrd});
            chk($sformatf("v%0d_mem_write", i), {127'd0, mem_write}, {127'd0, vecs[i].e_mwr});
            chk($sformatf("v%0d_empty", i), {127'd0, wbuf_empty}, {127'd0, vecs[i].e_emp});
            if (vecs[i].e_mwr) begin
                chk($sformatf("v%0d_mem_addr", i), {100'd0, mem_addr}, {100'd0, vecs[i].e_maddr});
                chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].e_mwdata);
            end
            if (vecs[i].c_rdata) begin
                chk($sformatf("v%0d_rdata", i), l2_rdata, vecs[i].e_rdata);
            end
        end
        l2_read = 1'b0; l2_write = 1'b0; mem_ready = 1'b0;
        tick();

        // Fill all four slots with memory stalled; a fifth write waits for a pop.
        sb_on = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sb_addr.push_back(28'h0000100 + 28'(i));
            sb_data.push_back({4{32'hA000_0000 + 32'(i)}});
        end
        for (int i = 0; i < 4; i++) begin
            do_write(28'h0000100 + 28'(i), {4{32'hA000_0000 + 32'(i)}});
        end
        l2_write = 1'b1;
        l2_addr  = 28'h0000104;
        l2_wdata = {4{32'hA000_0004}};
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("full_stall_%0d", k), {127'd0, l2_ready}, 128'd0);
        end
        chk("full_head_write", {127'd0, mem_write}, 128'd1);
        chk("full_head_addr", {100'd0, mem_addr}, 128'h100);
        mem_ready = 1'b1;
        tick();
        chk("full_pop_cycle_no_ack", {127'd0, l2_ready}, 128'd0);
        mem_ready = 1'b0;
        tick();
        chk("full_ack_after_free", {127'd0, l2_ready}, 128'd1);
        l2_write  = 1'b0;
        mem_ready = 1'b1;
        wait_empty("full_drain_empty");
        chk("full_drain_all_seen", 128'(sb_addr.size()), 128'd0);
        mem_ready = 1'b0;
        tick();

        // Dirty eviction: write B then immediately read C; the read reaches memory first.
        sb_addr.push_back(28'h0000B00);
        sb_data.push_back({4{32'hBBBB_0000}});
        do_write(28'h0000B00, {4{32'hBBBB_0000}});
        l2_read = 1'b1;
        l2_addr = 28'h0000C00;
        tick();
        chk("evict_t1_no_mem_write", {127'd0, mem_write}, 128'd0);
        tick();
        chk("evict_t2_no_mem_write", {127'd0, mem_write}, 128'd0);
        chk("evict_t2_no_mem_read", {127'd0, mem_read}, 128'd0);
        tick();
        chk("evict_mem_read", {127'd0, mem_read}, 128'd1);
        chk("evict_mem_read_addr", {100'd0, mem_addr}, 128'hC00);
        chk("evict_write_deferred", {127'd0, mem_write}, 128'd0);
        tick();
        chk("evict_mem_read_held", {127'd0, mem_read}, 128'd1);
        mem_rdata = {4{32'hC0C0_C0C0}};
        mem_ready = 1'b1;
        tick();
        chk("evict_read_ready", {127'd0, l2_ready}, 128'd1);
        chk("evict_read_data", l2_rdata, {4{32'hC0C0_C0C0}});
        chk("evict_read_dropped", {127'd0, mem_read}, 128'd0);
        l2_read   = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = {4{32'h5555_5555}};
        tick();
        chk("evict_rdata_hold1", l2_rdata, {4{32'hC0C0_C0C0}});
        chk("evict_ready_pulse_once", {127'd0, l2_ready}, 128'd0);
        tick();
        chk("evict_rdata_hold2", l2_rdata, {4{32'hC0C0_C0C0}});
        chk("evict_b_drain", {127'd0, mem_write}, 128'd1);
        chk("evict_b_addr", {100'd0, mem_addr}, 128'hB00);
        mem_ready = 1'b1;
        wait_empty("evict_empty");
        chk("evict_all_seen", 128'(sb_addr.size()), 128'd0);
        mem_ready = 1'b0;
        sb_on     = 1'b0;
        tick();

        // Reset while draining with three entries queued.
        for (int i = 0; i < 3; i++) begin
            do_write(28'h0000E00 + 28'(i), {4{32'hE000_0000 + 32'(i)}});
        end
        tick();
        chk("pre_rst_mem_write", {127'd0, mem_write}, 128'd1);
        chk("pre_rst_not_empty", {127'd0, wbuf_empty}, 128'd0);
        proc_reset_n = 1'b0;
        tick();
        chk("mid_rst_mem_write", {127'd0, mem_write}, 128'd0);
        chk("mid_rst_empty", {127'd0, wbuf_empty}, 128'd1);
        chk("mid_rst_ready", {127'd0, l2_ready}, 128'd0);
        chk("mid_rst_mem_addr", {100'd0, mem_addr}, 128'd0);
        chk("mid_rst_rdata", l2_rdata, 128'd0);
        proc_reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("post_rst_idle_%0d", k), {126'd0, mem_write, l2_ready}, 128'd0);
        end
        // Discarded entries must no longer forward: the read goes to memory.
        l2_read = 1'b1;
        l2_addr = 28'h0000E01;
        begin
            logic got;
            got = 1'b0;
            for (int k = 0; k < 10; k++) begin
                tick();
                chk($sformatf("post_rst_no_fwd_%0d", k), {127'd0, l2_ready}, 128'd0);
                if (mem_read) begin
                    got = 1'b1;
                    break;
                end
            end
            chk("post_rst_miss_issued", {127'd0, got}, 128'd1);
        end
        chk("post_rst_miss_addr", {100'd0, mem_addr}, 128'hE01);
        mem_rdata = {4{32'h7777_0001}};
        mem_ready = 1'b1;
        tick();
        chk("post_rst_miss_ready", {127'd0, l2_ready}, 128'd1);
        chk("post_rst_miss_data", l2_rdata, {4{32'h7777_0001}});
        l2_read   = 1'b0;
        mem_ready = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/dcache_l2_wbuf.md
Name: dcache_l2_wbuf

Overview:
- Posted write buffer between the L2 data cache's memory port and main memory.
- Accepts 128-bit line write-backs from L2 and acknowledges them without waiting for memory.
- Queues those writes and drains them to memory in the background.
- Services L2 line reads by forwarding from the buffer when the line is queued, otherwise by a memory read.
- Hides memory write latency on dirty-eviction sequences (write-back immediately followed by refill read).

Parameters:
- DEPTH, 4, number of buffered line entries (power of 2, >=2)
- PTR_W, 2, log2(DEPTH)

Ports:
- clk  input  1  single clock, all state on posedge
- proc_reset_n  input  1  synchronous active-low reset
- l2_read  input  1  L2 line read request, level, held until acknowledged
- l2_write  input  1  L2 line write request, level, held until acknowledged
- l2_addr  input  28  line address {tag,set}
- l2_wdata  input  128  write line data
- l2_rdata  output  128  read line data, registered
- l2_ready  output  1  one-cycle acknowledge pulse
- mem_read  output  1  memory read request, level
- mem_write  output  1  memory write request, level
- mem_addr  output  28  memory line address
- mem_wdata  output  128  memory write data
- mem_rdata  input  128  memory read data, valid in the mem_ready cycle
- mem_ready  input  1  memory one-cycle acknowledge
- wbuf_empty  output  1  high when count==0 and memory FSM is idle

Behaviour:
- Interface decided: one clock clk; reset proc_reset_n is synchronous, active-low.
- Reset values (also when reset is applied mid-operation):
  - outputs: l2_ready=0, l2_rdata=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, wbuf_empty=1
  - state: count=0, pointers=0, entries invalid, both FSMs idle
  - pending buffered writes are discarded; requests drop the cycle after reset is sampled
- Request decode:
  - read = l2_read & ~l2_write; write = l2_write & ~l2_read
  - both high, or both low: no action
- Upstream FSM states: U_IDLE, U_ACK, U_RDMISS.
- U_IDLE, write, count<DEPTH:
  - enqueue {l2_addr, l2_wdata} at wr_ptr, increment wr_ptr and count
  - l2_ready=1 next cycle (U_ACK)
- U_IDLE, write, count==DEPTH: stall in U_IDLE, no ready; enqueue in the first cycle count<DEPTH.
- U_IDLE, read, address matches one or more valid entries:
  - forward the youngest matching entry into l2_rdata
  - l2_ready next cycle (U_ACK)
- U_IDLE, read, no match:
  - go to U_RDMISS and post a read request to the memory FSM
  - when memory data is captured: l2_rdata<=mem_rdata, l2_ready next cycle (U_ACK)
- U_ACK: l2_ready=1 for exactly this cycle; ignore l2_read/l2_write this cycle (L2 still holds its old request); return to U_IDLE.
- l2_rdata holds its value until the next read completes, so L2's registered-ready sampling one cycle later sees valid data.
- Memory FSM states: M_IDLE, M_READ, M_WRITE.
- M_IDLE priority:
  - a pending read miss goes first, to M_READ with mem_addr=l2_addr
  - otherwise, if count>0, go to M_WRITE with mem_addr/mem_wdata from the head entry
- Memory requests, addresses and data are registered and held stable until mem_ready.
- On mem_ready, request drops the next cycle and the FSM returns to M_IDLE:
  - M_WRITE: pop the head, advance rd_ptr, decrement count
  - M_READ: capture mem_rdata
- No back-to-back memory request without one M_IDLE cycle in between.
- Enqueue and dequeue in the same cycle: count unchanged; pointers wrap modulo DEPTH.
- The head entry being drained stays valid and is still forwardable until popped.
- Ordering:
  - a read miss never targets an address still in the buffer, since the match check happens first and no new writes enter during U_RDMISS
  - writes reach memory in FIFO order; duplicates are not coalesced
- Latency:
  - write accept: l2_ready 1 cycle after request when not full
  - forwarded read: 1 cycle
  - read miss: memory latency + ~3 cycles

Test Plan:
- Reset, then write A=0x0000010 data D1 -> l2_ready at cycle t+1; mem_write to 0x0000010 with D1 follows; count returns to 0; wbuf_empty=1.
- Write A then read A while mem_ready is held low -> read forwarded in 1 cycle, l2_rdata=D1, no mem_read issued.
- Write A with D1, then A with D2, then read A -> l2_rdata=D2 (youngest); memory later receives D1 then D2 in order.
- Write 4 distinct lines with memory stalled, then a 5th -> 5th gets no l2_ready until the first mem_ready; it is then acknowledged 1 cycle after the freed slot.
- Dirty-eviction pattern (write B, then read C at t+2) -> mem_read for C wins over the B drain; l2_rdata=mem_rdata is held 2+ cycles; B is drained afterwards.
- Assert proc_reset_n=0 while in M_WRITE with 3 entries -> next cycle mem_write=0, count=0, wbuf_empty=1, no ready pulse.
